// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   // Arbiter FSM: idle (sampling requests) or an access in flight for one port
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   // Read data returned to a requester whose access was aborted by the watchdog
   localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction cache
// (port 0, read-only) and the core data port (port 1, read/write).
// A grant is held until mem_done or until the watchdog expires; an expired
// access completes with err=1 and rdata=ERR_RDATA so no requester hangs.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,

   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic                  p0_rstrb,
   output logic [31:0]           p0_rdata,
   output logic                  p0_done,
   output logic                  p0_err,

   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [31:0]           p1_wdata,
   input  logic [3:0]            p1_wmask,
   input  logic                  p1_rstrb,
   input  logic                  p1_wstrb,
   output logic [31:0]           p1_rdata,
   output logic                  p1_done,
   output logic                  p1_err,

   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_wmask,
   output logic                  mem_rstrb,
   output logic                  mem_wstrb,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_done
);

   // Watchdog counter is wide enough to hold TIMEOUT; expiry fires on the
   // last in-flight cycle so done/err land TIMEOUT cycles after the strobe rises.
   localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int LAST_VAL = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = LAST_VAL[CNT_W-1:0];

   arb_state_t            state_reg, state_next;
   logic                  last_reg, last_next;     // port granted most recently
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [31:0]           wdata_reg, wdata_next;
   logic [3:0]            wmask_reg, wmask_next;
   logic                  rstrb_reg, rstrb_next;
   logic                  wstrb_reg, wstrb_next;
   logic [31:0]           rdata0_reg, rdata0_next;
   logic [31:0]           rdata1_reg, rdata1_next;
   logic                  done0_reg, done0_next;
   logic                  done1_reg, done1_next;
   logic                  err0_reg, err0_next;
   logic                  err1_reg, err1_next;

   logic req0, req1, grant1, expired;

   // A strobe still shown during that port's done cycle belongs to the
   // finished access and must not start a second one.
   assign req0    = p0_rstrb && !done0_reg;
   assign req1    = (p1_rstrb || p1_wstrb) && !done1_reg;
   // Port 1 wins when it is alone, or on a tie when port 0 was served last.
   assign grant1  = req1 && (!req0 || !last_reg);
   assign expired = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

   // State and datapath registers; reset drops strobes immediately
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg  <= IDLE;
         last_reg   <= 1'b1;
         cnt_reg    <= '0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         wmask_reg  <= '0;
         rstrb_reg  <= 1'b0;
         wstrb_reg  <= 1'b0;
         rdata0_reg <= '0;
         rdata1_reg <= '0;
         done0_reg  <= 1'b0;
         done1_reg  <= 1'b0;
         err0_reg   <= 1'b0;
         err1_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         last_reg   <= last_next;
         cnt_reg    <= cnt_next;
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
         wmask_reg  <= wmask_next;
         rstrb_reg  <= rstrb_next;
         wstrb_reg  <= wstrb_next;
         rdata0_reg <= rdata0_next;
         rdata1_reg <= rdata1_next;
         done0_reg  <= done0_next;
         done1_reg  <= done1_next;
         err0_reg   <= err0_next;
         err1_reg   <= err1_next;
      end
   end

   // Next-state logic: grant in IDLE, complete or time out in GNT0/GNT1
   always_comb begin
      state_next  = state_reg;
      last_next   = last_reg;
      cnt_next    = cnt_reg;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      wmask_next  = wmask_reg;
      rstrb_next  = rstrb_reg;
      wstrb_next  = wstrb_reg;
      rdata0_next = rdata0_reg;
      rdata1_next = rdata1_reg;
      done0_next  = 1'b0;
      done1_next  = 1'b0;
      err0_next   = 1'b0;
      err1_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (grant1) begin
               state_next = GNT1;
               last_next  = 1'b1;
               cnt_next   = '0;
               addr_next  = p1_addr;
               wdata_next = p1_wdata;
               wmask_next = p1_wmask;
               // Both strobes high is illegal and resolves to a write
               wstrb_next = p1_wstrb;
               rstrb_next = !p1_wstrb;
            end else if (req0) begin
               state_next = GNT0;
               last_next  = 1'b0;
               cnt_next   = '0;
               addr_next  = p0_addr;
               wdata_next = '0;
               wmask_next = '0;
               wstrb_next = 1'b0;
               rstrb_next = 1'b1;
            end
         end

         GNT0, GNT1: begin
            if (mem_done || expired) begin
               state_next = IDLE;
               rstrb_next = 1'b0;
               wstrb_next = 1'b0;
               if (state_reg == GNT0) begin
                  rdata0_next = mem_done ? mem_rdata : ERR_RDATA;
                  done0_next  = 1'b1;
                  err0_next   = !mem_done;
               end else begin
                  rdata1_next = mem_done ? mem_rdata : ERR_RDATA;
                  done1_next  = 1'b1;
                  err1_next   = !mem_done;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign p0_rdata  = rdata0_reg;
   assign p0_done   = done0_reg;
   assign p0_err    = err0_reg;
   assign p1_rdata  = rdata1_reg;
   assign p1_done   = done1_reg;
   assign p1_err    = err1_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign mem_wmask = wmask_reg;
   assign mem_rstrb = rstrb_reg;
   assign mem_wstrb = wstrb_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] p0_addr = '0;
   logic          p0_rstrb = 1'b0;
   logic [31:0]   p0_rdata;
   logic          p0_done, p0_err;
   logic [AW-1:0] p1_addr = '0;
   logic [31:0]   p1_wdata = '0;
   logic [3:0]    p1_wmask = '0;
   logic          p1_rstrb = 1'b0;
   logic          p1_wstrb = 1'b0;
   logic [31:0]   p1_rdata;
   logic          p1_done, p1_err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_wmask;
   logic          mem_rstrb, mem_wstrb;
   logic [31:0]   mem_rdata = '0;
   logic          mem_done = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .p0_addr(p0_addr), .p0_rstrb(p0_rstrb), .p0_rdata(p0_rdata),
      .p0_done(p0_done), .p0_err(p0_err),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
      .p1_rstrb(p1_rstrb), .p1_wstrb(p1_wstrb), .p1_rdata(p1_rdata),
      .p1_done(p1_done), .p1_err(p1_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rstrb(mem_rstrb), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_done(mem_done)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // One access record (who owns the bus, what kind, how long it has waited)
   // plus the round-robin pointer and each port's visible result.
   bit          m_busy = 0;
   int          m_owner = 0;
   bit          m_write = 0;
   logic [31:0] m_addr = '0, m_wdata = '0;
   logic [3:0]  m_wmask = '0;
   int          m_age = 0;
   int          m_last = 1;
   logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
   bit          m_done [2] = '{0, 0};
   bit          m_err  [2] = '{0, 0};

   always @(posedge clk or negedge rst_n) begin : model
      bit r0, r1, fin, er;
      int win;
      logic [31:0] rd;
      if (!rst_n) begin
         m_busy = 0; m_owner = 0; m_write = 0; m_age = 0; m_last = 1;
         m_addr = '0; m_wdata = '0; m_wmask = '0;
         m_rdata[0] = '0; m_rdata[1] = '0;
         m_done[0] = 0; m_done[1] = 0; m_err[0] = 0; m_err[1] = 0;
      end else begin
         r0 = p0_rstrb && !m_done[0];
         r1 = (p1_rstrb || p1_wstrb) && !m_done[1];
         m_done[0] = 0; m_done[1] = 0; m_err[0] = 0; m_err[1] = 0;
         fin = 0; er = 0; rd = '0;
         if (m_busy) begin
            m_age++;
            if (mem_done) begin
               fin = 1; rd = mem_rdata;
            end else if (m_age == TO) begin
               fin = 1; er = 1; rd = 32'h0;
            end
            if (fin) begin
               m_busy = 0;
               m_rdata[m_owner] = rd;
               m_done[m_owner] = 1;
               m_err[m_owner] = er;
               $display("txn port%0d %s addr=%h rdata=%h err=%0d",
                        m_owner, m_write ? "wr" : "rd", m_addr, rd, er);
            end
         end else if (r0 || r1) begin
            win = (r0 && r1) ? 1 - m_last : (r0 ? 0 : 1);
            m_busy = 1; m_owner = win; m_last = win; m_age = 0;
            if (win == 0) begin
               m_write = 0; m_addr = p0_addr;
            end else begin
               m_write = p1_wstrb; m_addr = p1_addr;
               m_wdata = p1_wdata; m_wmask = p1_wmask;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("p0_done", p0_done, m_done[0]);
      check("p0_err", p0_err, m_err[0]);
      check("p0_rdata", p0_rdata, m_rdata[0]);
      check("p1_done", p1_done, m_done[1]);
      check("p1_err", p1_err, m_err[1]);
      check("p1_rdata", p1_rdata, m_rdata[1]);
      check("mem_rstrb", mem_rstrb, m_busy && !m_write);
      check("mem_wstrb", mem_wstrb, m_busy && m_write);
      if (m_busy) check("mem_addr", mem_addr, m_addr);
      if (m_busy && m_write) begin
         check("mem_wdata", mem_wdata, m_wdata);
         check("mem_wmask", mem_wmask, m_wmask);
      end
      if (m_busy && m_owner == 0) check("mem_wmask_p0", mem_wmask, 4'h0);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] strb_seq [8];
      logic [1:0] done_seq [8];
      strb_seq = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
      done_seq = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

      repeat (3) @(negedge clk);
      check("rst mem_rstrb", mem_rstrb, 1'b0);
      check("rst p0_done", p0_done, 1'b0);
      check("rst p1_rdata", p1_rdata, 32'h0);
      rst_n = 1'b1;

      // Both ports request continuously from reset, memory answers at once
      p0_rstrb = 1; p0_addr = 32'h40;
      p1_wstrb = 1; p1_addr = 32'h80; p1_wdata = 32'hA5A5A5A5; p1_wmask = 4'hF;
      mem_done = 1; mem_rdata = 32'h11111111;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 7) begin
            p0_rstrb = 0; p1_wstrb = 0; mem_done = 0;
         end
         check("tie strobes", {mem_rstrb, mem_wstrb}, strb_seq[i]);
         check("tie dones", {p0_done, p1_done}, done_seq[i]);
      end
      @(negedge clk);

      // Port 0 read, memory answers in the second strobe cycle; strobe held after done
      p0_rstrb = 1; p0_addr = 32'h100;
      @(negedge clk);
      check("p0rd mem_rstrb c1", mem_rstrb, 1'b1);
      check("p0rd mem_addr", mem_addr, 32'h100);
      @(negedge clk);
      check("p0rd mem_rstrb c2", mem_rstrb, 1'b1);
      mem_done = 1; mem_rdata = 32'hCAFEBABE;
      @(negedge clk);
      mem_done = 0;
      check("p0rd done", p0_done, 1'b1);
      check("p0rd rdata", p0_rdata, 32'hCAFEBABE);
      check("p0rd err", p0_err, 1'b0);
      check("p0rd strobe low", mem_rstrb, 1'b0);
      @(negedge clk);
      p0_rstrb = 0;
      check("held strobe no access", mem_rstrb, 1'b0);
      check("held strobe no done", p0_done, 1'b0);
      @(negedge clk);
      check("held strobe idle", mem_rstrb, 1'b0);

      // Port 1 write with immediate response
      p1_wstrb = 1; p1_addr = 32'h2000; p1_wdata = 32'h12345678; p1_wmask = 4'b0011;
      @(negedge clk);
      check("p1wr wstrb", mem_wstrb, 1'b1);
      check("p1wr rstrb", mem_rstrb, 1'b0);
      check("p1wr wmask", mem_wmask, 4'b0011);
      check("p1wr wdata", mem_wdata, 32'h12345678);
      check("p1wr addr", mem_addr, 32'h2000);
      mem_done = 1; mem_rdata = 32'hDEAD0001;
      @(negedge clk);
      mem_done = 0; p1_wstrb = 0;
      check("p1wr done", p1_done, 1'b1);
      check("p1wr err", p1_err, 1'b0);
      @(negedge clk);

      // Port 1 read that memory never answers
      p1_rstrb = 1; p1_addr = 32'h3000;
      for (int k = 1; k <= TO; k++) begin
         @(negedge clk);
         check("to waiting no done", p1_done, 1'b0);
         check("to waiting strobe", mem_rstrb, 1'b1);
      end
      @(negedge clk);
      p1_rstrb = 0;
      check("to done", p1_done, 1'b1);
      check("to err", p1_err, 1'b1);
      check("to rdata", p1_rdata, 32'h0);
      check("to strobe low", mem_rstrb, 1'b0);
      @(negedge clk);
      mem_done = 1; mem_rdata = 32'h77777777;
      @(negedge clk);
      mem_done = 0;
      check("stray no done", p1_done, 1'b0);
      p1_rstrb = 1;
      @(negedge clk);
      mem_done = 1; mem_rdata = 32'h0BADF00D;
      @(negedge clk);
      mem_done = 0; p1_rstrb = 0;
      check("after to done", p1_done, 1'b1);
      check("after to err", p1_err, 1'b0);
      check("after to rdata", p1_rdata, 32'h0BADF00D);
      @(negedge clk);

      // Reset while port 0 is granted
      p0_rstrb = 1; p0_addr = 32'h500;
      @(negedge clk);
      check("rstmid strobe before", mem_rstrb, 1'b1);
      #2 rst_n = 0;
      #1;
      check("rstmid strobe async drop", mem_rstrb, 1'b0);
      p0_rstrb = 0;
      @(negedge clk);
      check("rstmid no done", p0_done, 1'b0);
      @(negedge clk);
      rst_n = 1;
      p0_rstrb = 1; p1_rstrb = 1; p1_addr = 32'h600;
      @(negedge clk);
      check("rstmid tie to p0", mem_addr, 32'h500);
      mem_done = 1; mem_rdata = 32'h55AA55AA;
      @(negedge clk);
      mem_done = 0; p0_rstrb = 0;
      check("rstmid p0 done", p0_done, 1'b1);
      @(negedge clk);
      check("rstmid then p1", mem_addr, 32'h600);
      mem_done = 1;
      @(negedge clk);
      mem_done = 0; p1_rstrb = 0;
      check("rstmid p1 done", p1_done, 1'b1);
      @(negedge clk);

      // Randomized requesters and memory
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (p0_rstrb) begin
            if (m_done[0]) p0_rstrb = 1'($urandom_range(0, 1));
         end else if ($urandom_range(0, 3) == 0) begin
            p0_rstrb = 1; p0_addr = $urandom;
         end
         if (p1_rstrb || p1_wstrb) begin
            if (m_done[1] && $urandom_range(0, 1) == 1) begin
               p1_rstrb = 0; p1_wstrb = 0;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            int kind;
            kind = $urandom_range(0, 7);
            p1_addr = $urandom; p1_wdata = $urandom; p1_wmask = 4'($urandom);
            p1_wstrb = (kind <= 3);
            p1_rstrb = (kind == 0) || (kind >= 4);
         end
         mem_done = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         mem_rdata = $urandom;
      end
      p0_rstrb = 0; p1_rstrb = 0; p1_wstrb = 0; mem_done = 0;
      repeat (TO + 3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
